// File: rtl/aes_decipher_iter.sv
// rtl/aes_decipher_iter.sv - iterative AES-128 inverse cipher, one round per clock
// Round keys are regenerated on the fly: forward expansion to rk10, then inverse steps down to rk0.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign q = TABLE[11'd2047 - {a, 3'b000} -: 8];
endmodule

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);
  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign q = TABLE[11'd2047 - {a, 3'b000} -: 8];
endmodule

module aes_decipher_iter #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic         ready,
  output logic         out_valid,
  output logic [127:0] dataout
);
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   kcnt_q, kcnt_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] kreg_q, kreg_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] st_q, st_d;
  logic [127:0] dataout_q, dataout_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk_q, cache_rk_d;
  logic         cache_vld_q, cache_vld_d;
  logic         out_valid_q, out_valid_d;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    case (k)
      4'd9:    gmul = x8 ^ x;
      4'd11:   gmul = x8 ^ x2 ^ x;
      4'd13:   gmul = x8 ^ x4 ^ x;
      4'd14:   gmul = x8 ^ x4 ^ x2;
      default: gmul = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    inv_mix_col = {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                   gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                   gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                   gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Key schedule: one shared SubWord serves both the forward and the inverse step.
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_in, rot_w, sub_out, f_w;
  logic [3:0]   rcon_idx;
  logic [31:0]  fw0, fw1, fw2, fw3;
  logic [127:0] rk_fwd, rk_inv;

  assign w0       = rk_q[127:96];
  assign w1       = rk_q[95:64];
  assign w2       = rk_q[63:32];
  assign w3       = rk_q[31:0];
  assign sub_in   = (fsm_q == KEYEXP) ? w3 : (w2 ^ w3);
  assign rot_w    = {sub_in[23:0], sub_in[31:24]};
  assign rcon_idx = (fsm_q == KEYEXP) ? kcnt_q : (rnd_q + 4'd1);
  assign f_w      = sub_out ^ {rcon(rcon_idx), 24'h000000};

  for (genvar j = 0; j < 4; j++) begin : g_ks_sbox
    aes_sbox u_sbox (
      .a (rot_w[31-8*j -: 8]),
      .q (sub_out[31-8*j -: 8])
    );
  end

  assign fw0    = w0 ^ f_w;
  assign fw1    = fw0 ^ w1;
  assign fw2    = fw1 ^ w2;
  assign fw3    = fw2 ^ w3;
  assign rk_fwd = {fw0, fw1, fw2, fw3};
  assign rk_inv = {w0 ^ f_w, w0 ^ w1, w1 ^ w2, w2 ^ w3};

  // InvShiftRows is pure wiring: byte (r,c) takes the input byte from column (c-r) mod 4.
  logic [127:0] isb, t, mixed;

  for (genvar i = 0; i < 16; i++) begin : g_inv_sbox
    localparam int ROW = i % 4;
    localparam int COL = i / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    aes_inv_sbox u_inv_sbox (
      .a (st_q[127-8*SRC -: 8]),
      .q (isb[127-8*i -: 8])
    );
  end

  assign t     = isb ^ rk_inv;
  assign mixed = {inv_mix_col(t[127:96]), inv_mix_col(t[95:64]),
                  inv_mix_col(t[63:32]),  inv_mix_col(t[31:0])};

  always_comb begin
    fsm_d       = fsm_q;
    kcnt_d      = kcnt_q;
    rnd_d       = rnd_q;
    ct_d        = ct_q;
    kreg_d      = kreg_q;
    rk_d        = rk_q;
    st_d        = st_q;
    dataout_d   = dataout_q;
    cache_key_d = cache_key_q;
    cache_rk_d  = cache_rk_q;
    cache_vld_d = cache_vld_q;
    out_valid_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          ct_d   = datain;
          kreg_d = key;
          kcnt_d = 4'd1;
          if ((KEY_CACHE != 0) && cache_vld_q && (key == cache_key_q)) begin
            rk_d  = cache_rk_q;
            st_d  = datain ^ cache_rk_q;
            rnd_d = 4'd9;
            fsm_d = ROUND;
          end else begin
            rk_d  = key;
            fsm_d = KEYEXP;
          end
        end
      end
      KEYEXP: begin
        rk_d   = rk_fwd;
        kcnt_d = kcnt_q + 4'd1;
        if (kcnt_q == 4'd10) begin
          st_d        = ct_q ^ rk_fwd;
          cache_key_d = kreg_q;
          cache_rk_d  = rk_fwd;
          cache_vld_d = 1'b1;
          rnd_d       = 4'd9;
          fsm_d       = ROUND;
        end
      end
      ROUND: begin
        rk_d = rk_inv;
        if (rnd_q == 4'd0) begin
          dataout_d   = t;
          out_valid_d = 1'b1;
          fsm_d       = IDLE;
        end else begin
          st_d  = mixed;
          rnd_d = rnd_q - 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      kcnt_q      <= 4'd0;
      rnd_q       <= 4'd0;
      ct_q        <= 128'd0;
      kreg_q      <= 128'd0;
      rk_q        <= 128'd0;
      st_q        <= 128'd0;
      dataout_q   <= 128'd0;
      cache_key_q <= 128'd0;
      cache_rk_q  <= 128'd0;
      cache_vld_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      kcnt_q      <= kcnt_d;
      rnd_q       <= rnd_d;
      ct_q        <= ct_d;
      kreg_q      <= kreg_d;
      rk_q        <= rk_d;
      st_q        <= st_d;
      dataout_q   <= dataout_d;
      cache_key_q <= cache_key_d;
      cache_rk_q  <= cache_rk_d;
      cache_vld_q <= cache_vld_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ready     = (fsm_q == IDLE);
  assign out_valid = out_valid_q;
  assign dataout   = dataout_q;

endmodule

// File: doc/aes_decipher_iter.md
Name: aes_decipher_iter

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 InvCipher); the receive-side counterpart to aescipher.
- Takes a 128-bit ciphertext and the same 128-bit cipher key used by aescipher, and returns the plaintext.
- Performs one inverse round per clock.
- Computes the round-key schedule on the fly:
  - forward expansion derives rk10;
  - inverse stepping then derives rk9..rk0.
- Holds no 11-entry key RAM.
- Start/ready/valid handshake so the block can sit behind a link receiver.

Parameters:
KEY_CACHE, 1, 1 = skip forward key expansion when key equals the key of the last completed expansion; 0 = always expand.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when ready=1
datain  input  128  ciphertext, sampled on accepted start
key  input  128  cipher key, sampled on accepted start
ready  output  1  high in IDLE only
out_valid  output  1  one-cycle pulse, dataout newly valid
dataout  output  128  plaintext, held until the next completion

Behaviour:
- Byte order is identical to aescipher.
  - datain[127:120] = state byte 0.
  - Column-major: bytes 0..3 form column 0.
  - Key uses the same order.
- Reset: sampled on a clk edge with rst_n=0.
  - state=IDLE, ready=1, out_valid=0, dataout=0, internal registers=0, key-cache valid flag=0.
  - Reset mid-operation aborts the operation; no out_valid is produced.
- FSM states: IDLE, KEYEXP, ROUND.
- IDLE:
  - On start=1, capture datain into ct_reg and key into kreg.
  - Set rcon index to 1.
  - If KEY_CACHE=1, cache valid, and key equals cached_key: load rk_reg=cached_rk10, state_reg=datain^cached_rk10, go to ROUND with rnd=9.
  - Otherwise go to KEYEXP with kcnt=1.
- KEYEXP, 10 cycles (kcnt 1..10):
  - rk_reg <= next forward round key (RotWord, SubWord, Rcon[kcnt]).
  - At kcnt=10: state_reg <= ct_reg^rk10; cached_key<=kreg; cached_rk10<=rk10; cache valid<=1; go to ROUND with rnd=9.
- ROUND, rnd 9 down to 0, one per cycle:
  - t = InvSubBytes(InvShiftRows(state_reg)) ^ rk_{rnd}.
  - rk_{rnd} is derived combinationally from rk_reg=rk_{rnd+1} by the inverse schedule: w[i-4]=w[i]^f(w[i-1]) with Rcon[rnd+1].
  - rk_reg <= rk_{rnd}.
  - rnd 9..1: state_reg <= InvMixColumns(t).
  - rnd 0: dataout <= t (no InvMixColumns); out_valid=1 in the next cycle; state returns to IDLE.
- Latency from the accepting edge to the out_valid cycle:
  - 20 cycles with a full key expansion.
  - 10 cycles on a cache hit.
- out_valid is high for exactly one cycle, concurrent with ready=1 (IDLE).
  - A start in that same cycle is accepted (back-to-back operation).
- start while ready=0 is ignored; datain and key changes while busy have no effect.
- S-box and inverse S-box come from existing leaf lookup modules.
- GF(2^8) xtime is combinational: multiply by 9/11/13/14 is built from xtime chains.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, datain 69c4e0d86a7b0430d8cdb78070b4c55a -> dataout 00112233445566778899aabbccddeeff, out_valid exactly 20 cycles after start.
- Key 5468617473206D79204B756E67204675, datain 29C3505F571420F6402299B31A02D73A -> dataout 54776F204F6E65204E696E652054776F. The same vectors run through aescipher then aes_decipher_iter must round-trip.
- Repeat the previous vector immediately with the same key (KEY_CACHE=1) -> same dataout, out_valid after 10 cycles. With KEY_CACHE=0 -> 20 cycles.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, datain 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
  - Issued with start held high in the out_valid cycle of the prior op: accepted there, previous dataout stays stable until the new completion.
- Pulse start with new datain while busy at cycle 5 -> ignored; original result unchanged and on time. Assert rst_n=0 at cycle 12 -> next cycle ready=1, out_valid=0, dataout=0, no late pulse. Cache is invalidated, so the next op takes 20 cycles.
